// File: rtl/bpred_pkg.sv
// Shared branch-prediction types: the in-flight prediction record and the
// 2-bit BHT counter encodings used by both the BHT and the resolve queue.
package bpred_pkg;

    // PC / target width; the BHT and the resolve queue must agree on it.
    localparam int BP_ADDR_WIDTH = 32;

    // BHT 2-bit saturating counter states.
    localparam logic [1:0] SKIP_S = 2'd0;
    localparam logic [1:0] SKIP_W = 2'd1;
    localparam logic [1:0] TAKE_W = 2'd2;
    localparam logic [1:0] TAKE_S = 2'd3;

    // One prediction made by fetch, waiting for execute to resolve it.
    typedef struct packed {
        logic [BP_ADDR_WIDTH-1:0] pc;
        logic                     pred_take;
        logic [BP_ADDR_WIDTH-1:0] pred_npc;
    } pred_rec_t;

    // A resolve is wrong if either the direction or the target disagrees.
    function automatic logic is_mispredict(input pred_rec_t rec, input logic take,
                                           input logic [BP_ADDR_WIDTH-1:0] npc);
        return (take != rec.pred_take) || (npc != rec.pred_npc);
    endfunction

endpackage

// File: rtl/pred_fifo.sv
// In-order store of prediction records. Pointers carry one extra wrap bit so
// full and empty are distinguishable; flush drops every entry, including one
// being pushed in the same cycle.
module pred_fifo
    import bpred_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  pred_rec_t                wdata,
    output pred_rec_t                head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    pred_rec_t   mem_q [DEPTH];
    pred_rec_t   mem_d [DEPTH];

    // Next pointers and storage; flush snaps rd to wr and ignores any push.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q[AW-1:0]] = wdata;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
        end
    end

    // Pointer registers, cleared by reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Record storage; contents are don't-care until written.
    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
    end

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count = wr_ptr_q - rd_ptr_q;
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/branch_resolve_queue.sv
// Resolution-side partner of the BHT. Records fetch predictions in order,
// compares each oldest-first resolve against its prediction, drives the BHT
// update port and, on a mispredict, redirects fetch and flushes the queue.
module branch_resolve_queue
    import bpred_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = BP_ADDR_WIDTH,   // must equal BP_ADDR_WIDTH
    parameter int CNT_WIDTH  = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     ENQ_VALID,
    output logic                     ENQ_RDY,
    input  logic [ADDR_WIDTH-1:0]    ENQ_PC,
    input  logic                     ENQ_PRED_TAKE,
    input  logic [ADDR_WIDTH-1:0]    ENQ_PRED_NPC,
    input  logic                     RES_VALID,
    output logic                     RES_RDY,
    input  logic                     RES_TAKE,
    input  logic [ADDR_WIDTH-1:0]    RES_NPC,
    output logic [ADDR_WIDTH-1:0]    UPD_PC,
    output logic                     UPD_TAKE,
    output logic                     UPD_WE,
    output logic                     REDIR_VALID,
    output logic [ADDR_WIDTH-1:0]    REDIR_PC,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic [CNT_WIDTH-1:0]     MISP_CNT
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    pred_rec_t enq_rec, head;
    logic      full, empty;
    logic      enq_fire, res_fire, misp, flush;

    logic                  upd_we_q,      upd_we_d;
    logic [ADDR_WIDTH-1:0] upd_pc_q,      upd_pc_d;
    logic                  upd_take_q,    upd_take_d;
    logic                  redir_valid_q, redir_valid_d;
    logic [ADDR_WIDTH-1:0] redir_pc_q,    redir_pc_d;
    logic [CNT_WIDTH-1:0]  misp_cnt_q,    misp_cnt_d;

    // Ready signals depend only on stored pointers, never on the request side.
    assign ENQ_RDY  = !full;
    assign RES_RDY  = !empty;
    assign enq_fire = ENQ_VALID && ENQ_RDY;
    assign res_fire = RES_VALID && RES_RDY;
    assign misp     = is_mispredict(head, RES_TAKE, RES_NPC);
    assign flush    = res_fire && misp;
    assign enq_rec  = '{pc: ENQ_PC, pred_take: ENQ_PRED_TAKE, pred_npc: ENQ_PRED_NPC};

    pred_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (enq_fire),
        .pop   (res_fire),
        .flush (flush),
        .wdata (enq_rec),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (COUNT)
    );

    // Update/redirect payloads hold between pulses; counter saturates at all-ones.
    always_comb begin
        upd_we_d      = res_fire;
        redir_valid_d = flush;
        upd_pc_d      = upd_pc_q;
        upd_take_d    = upd_take_q;
        redir_pc_d    = redir_pc_q;
        misp_cnt_d    = misp_cnt_q;
        if (res_fire) begin
            upd_pc_d   = head.pc;
            upd_take_d = RES_TAKE;
        end
        if (flush) begin
            redir_pc_d = RES_NPC;
            if (misp_cnt_q != '1) misp_cnt_d = misp_cnt_q + CNT_ONE;
        end
    end

    // Output registers; reset wins over any pulse computed in the same cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            upd_we_q      <= 1'b0;
            upd_pc_q      <= '0;
            upd_take_q    <= 1'b0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
            misp_cnt_q    <= '0;
        end else begin
            upd_we_q      <= upd_we_d;
            upd_pc_q      <= upd_pc_d;
            upd_take_q    <= upd_take_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
            misp_cnt_q    <= misp_cnt_d;
        end
    end

    assign UPD_WE      = upd_we_q;
    assign UPD_PC      = upd_pc_q;
    assign UPD_TAKE    = upd_take_q;
    assign REDIR_VALID = redir_valid_q;
    assign REDIR_PC    = redir_pc_q;
    assign MISP_CNT    = misp_cnt_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Bench for branch_resolve_queue: directed vector table, full/wrap sequence,
// and randomized traffic against a queue-based reference model.
module tb_branch_resolve_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int CW    = 3;
    localparam int MC_MAX = (1 << CW) - 1;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          ENQ_VALID = 1'b0, ENQ_RDY;
    logic [AW-1:0] ENQ_PC = '0;
    logic          ENQ_PRED_TAKE = 1'b0;
    logic [AW-1:0] ENQ_PRED_NPC = '0;
    logic          RES_VALID = 1'b0, RES_RDY;
    logic          RES_TAKE = 1'b0;
    logic [AW-1:0] RES_NPC = '0;
    logic [AW-1:0] UPD_PC, REDIR_PC;
    logic          UPD_TAKE, UPD_WE, REDIR_VALID;
    logic [2:0]    COUNT;
    logic [CW-1:0] MISP_CNT;

    branch_resolve_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .CLK(CLK), .RST(RST),
        .ENQ_VALID(ENQ_VALID), .ENQ_RDY(ENQ_RDY), .ENQ_PC(ENQ_PC),
        .ENQ_PRED_TAKE(ENQ_PRED_TAKE), .ENQ_PRED_NPC(ENQ_PRED_NPC),
        .RES_VALID(RES_VALID), .RES_RDY(RES_RDY), .RES_TAKE(RES_TAKE), .RES_NPC(RES_NPC),
        .UPD_PC(UPD_PC), .UPD_TAKE(UPD_TAKE), .UPD_WE(UPD_WE),
        .REDIR_VALID(REDIR_VALID), .REDIR_PC(REDIR_PC),
        .COUNT(COUNT), .MISP_CNT(MISP_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit rst; bit ev; logic [31:0] epc; bit et; logic [31:0] enpc;
        bit rv; bit rt; logic [31:0] rnpc;
        int cnt; bit we; logic [31:0] upc; bit ut; bit rdv; logic [31:0] rpc;
        int mc; bit erdy; bit rrdy;
    } vec_t;

    typedef struct { logic [31:0] pc; bit t; logic [31:0] npc; } rec_t;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic chk_all(input string tag, input int cnt, input bit we, input logic [31:0] upc,
                           input bit ut, input bit rdv, input logic [31:0] rpc, input int mc,
                           input bit erdy, input bit rrdy);
        chk({tag, " COUNT"},       32'(COUNT),       32'(cnt));
        chk({tag, " UPD_WE"},      32'(UPD_WE),      32'(we));
        chk({tag, " UPD_PC"},      UPD_PC,           upc);
        chk({tag, " UPD_TAKE"},    32'(UPD_TAKE),    32'(ut));
        chk({tag, " REDIR_VALID"}, 32'(REDIR_VALID), 32'(rdv));
        chk({tag, " REDIR_PC"},    REDIR_PC,         rpc);
        chk({tag, " MISP_CNT"},    32'(MISP_CNT),    32'(mc));
        chk({tag, " ENQ_RDY"},     32'(ENQ_RDY),     32'(erdy));
        chk({tag, " RES_RDY"},     32'(RES_RDY),     32'(rrdy));
    endtask

    function automatic vec_t mk(bit rst, bit ev, logic [31:0] epc, bit et, logic [31:0] enpc,
                                bit rv, bit rt, logic [31:0] rnpc,
                                int cnt, bit we, logic [31:0] upc, bit ut, bit rdv,
                                logic [31:0] rpc, int mc, bit erdy, bit rrdy);
        vec_t v;
        v.rst = rst; v.ev = ev; v.epc = epc; v.et = et; v.enpc = enpc;
        v.rv = rv; v.rt = rt; v.rnpc = rnpc;
        v.cnt = cnt; v.we = we; v.upc = upc; v.ut = ut; v.rdv = rdv;
        v.rpc = rpc; v.mc = mc; v.erdy = erdy; v.rrdy = rrdy;
        return v;
    endfunction

    task automatic drive(input bit rst, input bit ev, input logic [31:0] epc, input bit et,
                         input logic [31:0] enpc, input bit rv, input bit rt,
                         input logic [31:0] rnpc);
        RST = rst; ENQ_VALID = ev; ENQ_PC = epc; ENQ_PRED_TAKE = et; ENQ_PRED_NPC = enpc;
        RES_VALID = rv; RES_TAKE = rt; RES_NPC = rnpc;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    vec_t tbl[$];
    rec_t mq[$];
    bit   m_we, m_ut, m_rdv;
    logic [31:0] m_upc, m_rpc;
    int   m_mc;

    initial begin
        // rst ev  epc   et enpc   rv rt rnpc  | cnt we upc  ut rdv rpc  mc erdy rrdy
        tbl.push_back(mk(1,0,0,0,0,          0,0,0,        0,0,0,0,0,0,0,1,0));
        tbl.push_back(mk(1,0,0,0,0,          0,0,0,        0,0,0,0,0,0,0,1,0));
        tbl.push_back(mk(0,0,0,0,0,          0,0,0,        0,0,0,0,0,0,0,1,0));
        // correct predict
        tbl.push_back(mk(0,1,'h100,1,'h140,  0,0,0,        1,0,0,0,0,0,0,1,1));
        tbl.push_back(mk(0,0,0,0,0,          1,1,'h140,    0,1,'h100,1,0,0,0,1,0));
        tbl.push_back(mk(0,0,0,0,0,          0,0,0,        0,0,'h100,1,0,0,0,1,0));
        // mispredict flush of three entries
        tbl.push_back(mk(0,1,'h100,0,'h104,  0,0,0,        1,0,'h100,1,0,0,0,1,1));
        tbl.push_back(mk(0,1,'h104,0,'h108,  0,0,0,        2,0,'h100,1,0,0,0,1,1));
        tbl.push_back(mk(0,1,'h108,0,'h10c,  0,0,0,        3,0,'h100,1,0,0,0,1,1));
        tbl.push_back(mk(0,0,0,0,0,          1,1,'h200,    0,1,'h100,1,1,'h200,1,1,0));
        tbl.push_back(mk(0,0,0,0,0,          0,0,0,        0,0,'h100,1,0,'h200,1,1,0));
        // same-cycle enqueue during mispredict is discarded
        tbl.push_back(mk(0,1,'h400,1,'h480,  0,0,0,        1,0,'h100,1,0,'h200,1,1,1));
        tbl.push_back(mk(0,1,'h404,0,'h408,  0,0,0,        2,0,'h100,1,0,'h200,1,1,1));
        tbl.push_back(mk(0,1,'h300,0,'h304,  1,0,'h404,    0,1,'h400,0,1,'h404,2,1,0));
        tbl.push_back(mk(0,0,0,0,0,          0,0,0,        0,0,'h400,0,0,'h404,2,1,0));
        // reset mid-flight suppresses the pending resolve
        tbl.push_back(mk(0,1,'h500,1,'h600,  0,0,0,        1,0,'h400,0,0,'h404,2,1,1));
        tbl.push_back(mk(0,1,'h504,1,'h600,  0,0,0,        2,0,'h400,0,0,'h404,2,1,1));
        tbl.push_back(mk(0,1,'h508,1,'h600,  0,0,0,        3,0,'h400,0,0,'h404,2,1,1));
        tbl.push_back(mk(1,0,0,0,0,          1,1,'h600,    0,0,0,0,0,0,0,1,0));
        tbl.push_back(mk(0,0,0,0,0,          0,0,0,        0,0,0,0,0,0,0,1,0));
        // resolve while empty is ignored
        tbl.push_back(mk(0,0,0,0,0,          1,1,'h999,    0,0,0,0,0,0,0,1,0));
        // target-only mispredict, then a correct not-taken resolve
        tbl.push_back(mk(0,1,'h700,1,'h740,  0,0,0,        1,0,0,0,0,0,0,1,1));
        tbl.push_back(mk(0,0,0,0,0,          1,1,'h744,    0,1,'h700,1,1,'h744,1,1,0));
        tbl.push_back(mk(0,1,'h710,0,'h714,  0,0,0,        1,0,'h700,1,0,'h744,1,1,1));
        tbl.push_back(mk(0,0,0,0,0,          1,0,'h714,    0,1,'h710,0,0,'h744,1,1,0));

        #2;
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].ev, tbl[i].epc, tbl[i].et, tbl[i].enpc,
                  tbl[i].rv, tbl[i].rt, tbl[i].rnpc);
            tick();
            chk_all($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].we, tbl[i].upc, tbl[i].ut,
                    tbl[i].rdv, tbl[i].rpc, tbl[i].mc, tbl[i].erdy, tbl[i].rrdy);
        end

        // Full and pointer wrap
        drive(1,0,0,0,0,0,0,0); tick();
        drive(0,0,0,0,0,0,0,0);
        mq.delete();
        for (int i = 0; i < DEPTH; i++) begin
            rec_t r;
            r.pc = 32'h1000 + 32'(i * 16); r.t = i[0]; r.npc = r.pc + 8;
            drive(0,1,r.pc,r.t,r.npc,0,0,0); tick();
            mq.push_back(r);
        end
        chk("full ENQ_RDY", 32'(ENQ_RDY), 0);
        chk("full COUNT", 32'(COUNT), DEPTH);
        drive(0,1,32'hdead0,1,32'hdead8,0,0,0); tick();
        chk("5th enq COUNT", 32'(COUNT), DEPTH);
        chk("5th enq ENQ_RDY", 32'(ENQ_RDY), 0);
        for (int r = 0; r < 10; r++) begin
            rec_t n, h;
            n.pc = 32'h2000 + 32'(r * 16); n.t = ~r[0]; n.npc = n.pc + 32'h40;
            h = mq.pop_front();
            drive(0,1,n.pc,n.t,n.npc,1,h.t,h.npc); tick();
            chk($sformatf("wrap%0d UPD_WE", r), 32'(UPD_WE), 1);
            chk($sformatf("wrap%0d UPD_PC", r), UPD_PC, h.pc);
            chk($sformatf("wrap%0d REDIR_VALID", r), 32'(REDIR_VALID), 0);
            chk($sformatf("wrap%0d COUNT after res", r), 32'(COUNT), DEPTH - 1);
            drive(0,1,n.pc,n.t,n.npc,0,0,0); tick();
            mq.push_back(n);
            chk($sformatf("wrap%0d COUNT", r), 32'(COUNT), DEPTH);
            chk($sformatf("wrap%0d ENQ_RDY", r), 32'(ENQ_RDY), 0);
        end

        // Randomized traffic against the reference model
        drive(1,0,0,0,0,0,0,0); tick();
        mq.delete();
        m_we = 0; m_ut = 0; m_rdv = 0; m_upc = 0; m_rpc = 0; m_mc = 0;
        for (int c = 0; c < 1500; c++) begin
            bit rst, ev, et, rv, rt, enq_ok, res_ok;
            logic [31:0] epc, enpc, rnpc;
            rst  = ($urandom_range(0, 59) == 0);
            ev   = ($urandom_range(0, 2) != 0);
            epc  = $urandom; et = 1'($urandom); enpc = $urandom;
            rv   = ($urandom_range(0, 1) != 0);
            rt   = 1'($urandom); rnpc = $urandom;
            if (mq.size() > 0 && $urandom_range(0, 4) != 0) begin
                rt = mq[0].t; rnpc = mq[0].npc;
                if ($urandom_range(0, 5) == 0) rnpc = rnpc ^ 32'h4;
            end
            drive(rst, ev, epc, et, enpc, rv, rt, rnpc);
            enq_ok = ev && (mq.size() < DEPTH);
            res_ok = rv && (mq.size() > 0);
            if (rst) begin
                mq.delete();
                m_we = 0; m_ut = 0; m_rdv = 0; m_upc = 0; m_rpc = 0; m_mc = 0;
            end else begin
                m_we = res_ok; m_rdv = 0;
                if (res_ok) begin
                    rec_t h;
                    h = mq.pop_front();
                    m_upc = h.pc; m_ut = rt;
                    if (rt != h.t || rnpc != h.npc) begin
                        m_rdv = 1; m_rpc = rnpc;
                        if (m_mc < MC_MAX) m_mc++;
                        mq.delete();
                        enq_ok = 0;
                    end
                end
                if (enq_ok) begin
                    rec_t n;
                    n.pc = epc; n.t = et; n.npc = enpc;
                    mq.push_back(n);
                end
            end
            tick();
            chk_all($sformatf("rnd%0d", c), mq.size(), m_we, m_upc, m_ut, m_rdv, m_rpc, m_mc,
                    mq.size() < DEPTH, mq.size() > 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
